// File: rtl/queue_reader_pkg.sv
// Shared sizes and state encoding for the queue drain controller.
// Imported by queue_reader and its round-robin arbiter.
package queue_reader_pkg;

    localparam int DEF_QUEUE_DEPTH = 8;
    localparam int DEF_DATA_WIDTH  = 8;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_SELECT = 2'd1,
        RD_POP    = 2'd2,
        RD_OUT    = 2'd3
    } rd_state_t;

endpackage

// File: rtl/queue_reader_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, else wraps.
// QUEUE_DEPTH must be a power of two so the index wraps naturally.
module rr_arbiter
    import queue_reader_pkg::*;
#(
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int PW          = $clog2(QUEUE_DEPTH)
) (
    input  logic [QUEUE_DEPTH-1:0] req,
    input  logic [PW-1:0]          ptr,
    output logic [QUEUE_DEPTH-1:0] gnt
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            idx = ptr + PW'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/queue_reader.sv
// Drain-side queue controller: round-robin slot select, single-cycle pop,
// and a registered valid/ready output stage.
module queue_reader
    import queue_reader_pkg::*;
#(
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [QUEUE_DEPTH-1:0] status,
    input  logic [DATA_WIDTH-1:0]  q_data,
    output logic [QUEUE_DEPTH-1:0] rd_sel,
    output logic                   pop,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy
);

    localparam int PW = $clog2(QUEUE_DEPTH);

    rd_state_t              state;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          next_ptr;
    logic [QUEUE_DEPTH-1:0] gnt;
    logic                   start;

    assign start = enable && (|status);
    assign busy  = (state != RD_IDLE);

    rr_arbiter #(
        .QUEUE_DEPTH(QUEUE_DEPTH),
        .PW         (PW)
    ) u_arb (
        .req(status),
        .ptr(ptr),
        .gnt(gnt)
    );

    // Slot after the one currently granted, wrapping at the top.
    always_comb begin
        next_ptr = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (rd_sel[i]) next_ptr = PW'(i) + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RD_IDLE;
            ptr     <= '0;
            rd_sel  <= '0;
            pop     <= 1'b0;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            pop <= 1'b0;
            unique case (state)
                RD_IDLE: begin
                    if (start) begin
                        rd_sel <= gnt;
                        state  <= RD_SELECT;
                    end else begin
                        rd_sel <= '0;
                    end
                end
                RD_SELECT: begin
                    if ((status & rd_sel) == '0) begin
                        rd_sel <= '0;
                        state  <= RD_IDLE;
                    end else begin
                        pop   <= 1'b1;
                        state <= RD_POP;
                    end
                end
                RD_POP: begin
                    m_data  <= q_data;
                    m_valid <= 1'b1;
                    rd_sel  <= '0;
                    ptr     <= next_ptr;
                    state   <= RD_OUT;
                end
                RD_OUT: begin
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        if (start) begin
                            rd_sel <= gnt;
                            state  <= RD_SELECT;
                        end else begin
                            state  <= RD_IDLE;
                        end
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_queue_reader.sv
// Directed testbench for queue_reader with a simple slot-data queue model.
module tb_queue_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] status = 8'h00;
    logic [7:0] q_data;
    logic [7:0] rd_sel;
    logic       pop;
    logic [7:0] m_data;
    logic       m_valid;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Slot i holds 8'hA0 + i; output is zero when nothing is selected.
    always_comb begin
        q_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (rd_sel[i]) q_data = q_data | (8'hA0 + 8'(i));
        end
    end

    queue_reader dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .status (status),
        .q_data (q_data),
        .rd_sel (rd_sel),
        .pop    (pop),
        .m_data (m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .busy   (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (m_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        bit ok;
        logic [18:0] outs;
        reset = 1'b1;
        tick();
        tick();
        outs = {rd_sel, pop, m_data, m_valid, busy};
        checks++;
        if (outs !== 19'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", outs);
        end
        reset = 1'b0;
        status = 8'h01;
        enable = 1'b1;
        m_ready = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_reach_out got=timeout exp=m_valid");
        end
        checks++;
        if (m_data !== 8'hA0) begin
            failures++;
            $display("FAIL reset_pre_data got=%h exp=a0", m_data);
        end
        reset = 1'b1;
        tick();
        outs = {rd_sel, pop, m_data, m_valid, busy};
        checks++;
        if (outs !== 19'h0) begin
            failures++;
            $display("FAIL reset_in_out got=%h exp=0", outs);
        end
        reset = 1'b0;
        status = 8'h00;
        tick();
    endtask

    task automatic test_single;
        status = 8'h04;
        enable = 1'b1;
        m_ready = 1'b1;
        tick();
        checks++;
        if ({rd_sel, pop, m_valid, busy} !== {8'h04, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL single_c1 got=%h,%b,%b,%b exp=04,0,0,1",
                     rd_sel, pop, m_valid, busy);
        end
        tick();
        checks++;
        if ({rd_sel, pop, m_valid} !== {8'h04, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL single_c2 got=%h,%b,%b exp=04,1,0",
                     rd_sel, pop, m_valid);
        end
        tick();
        checks++;
        if ({rd_sel, pop, m_valid, m_data} !== {8'h00, 1'b0, 1'b1, 8'hA2}) begin
            failures++;
            $display("FAIL single_c3 got=%h,%b,%b,%h exp=00,0,1,a2",
                     rd_sel, pop, m_valid, m_data);
        end
        status = 8'h00;
        tick();
        checks++;
        if ({m_valid, busy, pop} !== 3'b000) begin
            failures++;
            $display("FAIL single_done got=%b%b%b exp=000", m_valid, busy, pop);
        end
    endtask

    task automatic test_round_robin;
        logic [7:0] got [4];
        logic [7:0] exp [4];
        int n;
        bit ok;
        exp[0] = 8'hA0;
        exp[1] = 8'hA7;
        exp[2] = 8'hA0;
        exp[3] = 8'hA7;
        for (int i = 0; i < 4; i++) got[i] = 8'hXX;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        status = 8'h81;
        enable = 1'b1;
        m_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (m_valid) begin
                got[n] = m_data;
                n++;
                if (n == 4) status = 8'h00;
            end
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL rr_count got=%0d exp=4", n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++;
                $display("FAIL rr_word%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rr_idle got=busy exp=idle");
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        status = 8'h04;
        enable = 1'b1;
        m_ready = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_valid got=timeout exp=m_valid");
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({m_valid, m_data, pop} !== {1'b1, 8'hA2, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d got=%b,%h,%b exp=1,a2,0",
                         i, m_valid, m_data, pop);
            end
        end
        m_ready = 1'b1;
        tick();
        checks++;
        if ({m_valid, rd_sel, pop} !== {1'b0, 8'h04, 1'b0}) begin
            failures++;
            $display("FAIL bp_handshake got=%b,%h,%b exp=0,04,0",
                     m_valid, rd_sel, pop);
        end
        tick();
        checks++;
        if (pop !== 1'b1) begin
            failures++;
            $display("FAIL bp_pop_resume got=%b exp=1", pop);
        end
        status = 8'h00;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_idle got=busy exp=idle");
        end
    endtask

    task automatic test_vanish;
        status = 8'h10;
        enable = 1'b1;
        m_ready = 1'b1;
        tick();
        checks++;
        if ({rd_sel, busy} !== {8'h10, 1'b1}) begin
            failures++;
            $display("FAIL vanish_sel got=%h,%b exp=10,1", rd_sel, busy);
        end
        status = 8'h00;
        tick();
        checks++;
        if ({rd_sel, busy, pop} !== {8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL vanish_abort got=%h,%b,%b exp=00,0,0",
                     rd_sel, busy, pop);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({pop, m_valid, rd_sel, busy} !== 11'h0) begin
                failures++;
                $display("FAIL vanish_quiet%0d got=%b,%b,%h,%b exp=0,0,00,0",
                         i, pop, m_valid, rd_sel, busy);
            end
        end
    endtask

    task automatic test_enable_drop;
        bit ok;
        status = 8'hFF;
        enable = 1'b1;
        m_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (pop) ok = 1'b1;
        end
        checks++;
        if (!ok || rd_sel !== 8'h08) begin
            failures++;
            $display("FAIL drop_pop got=%b,%h exp=1,08", ok, rd_sel);
        end
        enable = 1'b0;
        tick();
        checks++;
        if ({m_valid, m_data} !== {1'b1, 8'hA3}) begin
            failures++;
            $display("FAIL drop_word got=%b,%h exp=1,a3", m_valid, m_data);
        end
        tick();
        checks++;
        if ({m_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL drop_idle got=%b%b exp=00", m_valid, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({pop, busy, rd_sel} !== 10'h0) begin
                failures++;
                $display("FAIL drop_quiet%0d got=%b,%b,%h exp=0,0,00",
                         i, pop, busy, rd_sel);
            end
        end
        status = 8'h00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_vanish();
        test_enable_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
